// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small character queue.
// Configurable data width, parity and stop bits; frames leave back-to-back while queued.
module uart_tx_fifo #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 send,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 busy,
    output logic                 tx_out
);

    localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
    localparam int BW = (BAUD_CLOCKS > 1) ? $clog2(BAUD_CLOCKS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CLOCKS - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 wr_en;
    logic                 pop;

    state_t               state;
    state_t               state_n;
    logic [BW-1:0]        baud_cnt;
    logic [BW-1:0]        baud_n;
    logic [IW-1:0]        bit_idx;
    logic [IW-1:0]        bit_n;
    logic                 stop_cnt;
    logic                 stop_n;
    logic [DATA_BITS-1:0] frame;
    logic                 baud_wrap;
    logic                 par_bit;
    logic                 tx_n;
    logic                 busy_n;

    assign wr_en     = send && !full;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign par_bit   = (PARITY_MODE == 2) ? ~^frame : ^frame;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // A write while full is dropped even if the FSM pops this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= send && full;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            frame    <= '0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            stop_cnt <= stop_n;
            tx_out   <= tx_n;
            busy     <= busy_n;
            if (pop) begin
                frame <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_wrap ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_idx;
        stop_n  = stop_cnt;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                baud_n = '0;
                if (!empty) begin
                    state_n = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (bit_idx == BIT_LAST) begin
                        state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                        stop_n  = 1'b0;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    state_n = STOP;
                    stop_n  = 1'b0;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (stop_cnt == STOP_LAST) begin
                        // Chain straight into the next frame when one is queued.
                        if (!empty) begin
                            state_n = START;
                            pop     = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        stop_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx_out stays a flop output.
    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != IDLE);
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = frame[bit_n];
            PARITY:  tx_n = par_bit;
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four configurations at 8 clocks per bit.
// Per-channel monitors decode the serial line and pop expected frames.
module tb_uart_tx_fifo;

    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din8 [3];
    logic [6:0] din7;
    logic       send [4];
    logic       full [4];
    logic       empty [4];
    logic       ovf [4];
    logic       busy [4];
    logic       tx [4];

    int cyc = 0;
    int rst_epoch = 0;
    int ovf_cnt = 0;
    int n_vec = 0;
    int n_err = 0;

    logic [9:0] exp_q [4][$];
    int         starts [4][$];

    int nbits [4] = '{8, 8, 8, 7};
    int pmode [4] = '{0, 1, 2, 0};
    int nstop [4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_epoch <= rst_epoch + 1;
    end

    always @(negedge clk) if (ovf[0] === 1'b1) ovf_cnt++;

    uart_tx_fifo #(
        .CLK_FREQUENCY(1_000_000), .BAUD_RATE(125_000),
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_8n1 (
        .clk(clk), .rst(rst), .din(din8[0]), .send(send[0]),
        .full(full[0]), .empty(empty[0]), .overflow(ovf[0]),
        .busy(busy[0]), .tx_out(tx[0])
    );

    uart_tx_fifo #(
        .CLK_FREQUENCY(1_000_000), .BAUD_RATE(125_000),
        .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_8e1 (
        .clk(clk), .rst(rst), .din(din8[1]), .send(send[1]),
        .full(full[1]), .empty(empty[1]), .overflow(ovf[1]),
        .busy(busy[1]), .tx_out(tx[1])
    );

    uart_tx_fifo #(
        .CLK_FREQUENCY(1_000_000), .BAUD_RATE(125_000),
        .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_8o1 (
        .clk(clk), .rst(rst), .din(din8[2]), .send(send[2]),
        .full(full[2]), .empty(empty[2]), .overflow(ovf[2]),
        .busy(busy[2]), .tx_out(tx[2])
    );

    uart_tx_fifo #(
        .CLK_FREQUENCY(1_000_000), .BAUD_RATE(125_000),
        .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_7n2 (
        .clk(clk), .rst(rst), .din(din7), .send(send[3]),
        .full(full[3]), .empty(empty[3]), .overflow(ovf[3]),
        .busy(busy[3]), .tx_out(tx[3])
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    task automatic drive(input int k, input logic [7:0] d);
        if (k == 3) din7 = d[6:0];
        else din8[k] = d;
        send[k] = 1'b1;
    endtask

    task automatic put(input int k, input logic [7:0] d);
        @(posedge clk); #1;
        drive(k, d);
        @(posedge clk); #1;
        send[k] = 1'b0;
    endtask

    task automatic wait_drain(input int k);
        int t = 0;
        while ((exp_q[k].size() != 0 || busy[k] !== 1'b0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(t < 2000), 32'd1);
    endtask

    task automatic monitor(input int k);
        logic        last = 1'b1;
        logic [15:0] sl;
        logic [9:0]  e;
        logic [8:0]  d;
        logic        fr_ok;
        int          ep, n, bad, ab, ps;
        forever begin
            @(negedge clk);
            if (last === 1'b1 && tx[k] === 1'b0) begin
                starts[k].push_back(cyc);
                ep  = rst_epoch;
                ps  = 1 + nbits[k];
                n   = ps + ((pmode[k] != 0) ? 1 : 0) + nstop[k];
                bad = 0;
                ab  = 0;
                sl  = '0;
                for (int i = 0; i < n && ab == 0; i++) begin
                    for (int j = 0; j < B && ab == 0; j++) begin
                        if (!(i == 0 && j == 0)) @(negedge clk);
                        if (rst_epoch != ep) ab = 1;
                        else if (j == 0) sl[i] = tx[k];
                        else if (tx[k] !== sl[i]) bad = 1;
                    end
                end
                last = tx[k];
                if (ab == 0) begin
                    if (exp_q[k].size() == 0) begin
                        chk("unexpected_frame", 32'(k), 32'hffff);
                    end else begin
                        e = exp_q[k].pop_front();
                        d = '0;
                        for (int b = 0; b < nbits[k]; b++) d[b] = sl[1 + b];
                        chk("frame_data", 32'(d), 32'(e[8:0]));
                        if (pmode[k] != 0) chk("parity", 32'(sl[ps]), 32'(e[9]));
                        fr_ok = (sl[0] === 1'b0) && (bad == 0);
                        for (int s = n - nstop[k]; s < n; s++)
                            if (sl[s] !== 1'b1) fr_ok = 1'b0;
                        chk("framing", 32'(fr_ok), 32'd1);
                    end
                end
            end else begin
                last = tx[k];
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t, lowcnt;
        for (int k = 0; k < 4; k++) send[k] = 1'b0;
        for (int k = 0; k < 3; k++) din8[k] = '0;
        din7 = '0;
        rst  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", 32'(tx[0]), 32'd1);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_empty", 32'(empty[0]), 32'd1);
        chk("rst_full", 32'(full[0]), 32'd0);
        chk("rst_ovf", 32'(ovf[0]), 32'd0);
        chk("rst_tx_7n2", 32'(tx[3]), 32'd1);

        // 8N1 single byte with latency and busy width
        exp_q[0].push_back({1'b0, 9'h0A5});
        put(0, 8'hA5);
        @(negedge clk);
        chk("lat_empty", 32'(empty[0]), 32'd0);
        chk("lat_tx_idle", 32'(tx[0]), 32'd1);
        @(negedge clk);
        chk("lat_tx_start", 32'(tx[0]), 32'd0);
        chk("lat_busy", 32'(busy[0]), 32'd1);
        repeat (10 * B - 1) @(negedge clk);
        chk("busy_last_stop", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("busy_end", 32'(busy[0]), 32'd0);
        chk("idle_tx", 32'(tx[0]), 32'd1);

        // Even / odd parity
        exp_q[1].push_back({1'b1, 9'h007});
        exp_q[2].push_back({1'b0, 9'h007});
        exp_q[1].push_back({1'b0, 9'h0A5});
        exp_q[2].push_back({1'b1, 9'h000});
        put(1, 8'h07);
        put(2, 8'h07);
        put(1, 8'hA5);
        put(2, 8'h00);
        wait_drain(1);
        wait_drain(2);
        if (starts[1].size() == 2)
            chk("gap_8e1", 32'(starts[1][1] - starts[1][0]), 32'(11 * B));
        else chk("frames_8e1", 32'(starts[1].size()), 32'd2);
        if (starts[2].size() == 2)
            chk("gap_8o1", 32'(starts[2][1] - starts[2][0]), 32'(11 * B));
        else chk("frames_8o1", 32'(starts[2].size()), 32'd2);

        // Burst of six with overflow on the last
        starts[0].delete();
        base = ovf_cnt;
        for (int i = 0; i < 5; i++)
            exp_q[0].push_back({1'b0, 1'b0, 8'(8'h11 * (i + 1))});
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 8'(8'h11 * (i + 1)));
            if (i == 5) begin
                @(negedge clk);
                chk("burst_full", 32'(full[0]), 32'd1);
            end
            @(posedge clk); #1;
        end
        send[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("ovf_pulses", 32'(ovf_cnt - base), 32'd1);
        wait_drain(0);
        chk("burst_frames", 32'(starts[0].size()), 32'd5);
        if (starts[0].size() == 5)
            for (int i = 1; i < 5; i++)
                chk("b2b_gap", 32'(starts[0][i] - starts[0][i-1]), 32'(10 * B));

        // Reset during data bit 3 with two bytes queued
        starts[0].delete();
        @(posedge clk); #1;
        drive(0, 8'hA5);
        @(posedge clk); #1;
        drive(0, 8'h01);
        @(posedge clk); #1;
        drive(0, 8'h02);
        @(posedge clk); #1;
        send[0] = 1'b0;
        t = 0;
        while (starts[0].size() == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("mid_start_seen", 32'(starts[0].size()), 32'd1);
        t = 0;
        while (starts[0].size() > 0 && cyc - starts[0][0] < 4 * B + B / 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", 32'(tx[0]), 32'd1);
        chk("mid_rst_empty", 32'(empty[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        starts[0].delete();
        lowcnt = 0;
        repeat (30 * B) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) lowcnt++;
        end
        chk("post_rst_quiet", 32'(lowcnt), 32'd0);
        chk("post_rst_frames", 32'(starts[0].size()), 32'd0);

        // 7N2, two queued bytes
        starts[3].delete();
        exp_q[3].push_back({1'b0, 9'h055});
        exp_q[3].push_back({1'b0, 9'h055});
        put(3, 8'h55);
        put(3, 8'h55);
        wait_drain(3);
        if (starts[3].size() == 2)
            chk("gap_7n2", 32'(starts[3][1] - starts[3][0]), 32'(10 * B));
        else chk("frames_7n2", 32'(starts[3].size()), 32'd2);

        for (int k = 0; k < 4; k++)
            chk("leftover", 32'(exp_q[k].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
